button_cursor_ctrl: RTL and testbench
=====================================

Name: button_cursor_ctrl

Overview:
Front-end input stage feeding the chess logic core. It synchronises and debounces the five board buttons, then maintains an 8x8 board cursor. A select/commit state machine turns two centre presses (from-square, then to-square) into one move request, which is handed to the chess logic with a valid/ready handshake. It runs on the 25 MHz system clock.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a debounced level changes (10 ms at 25 MHz); must be >= 2.
CNT_W, 18, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  25 MHz system clock.
reset  input  1  asynchronous, active-high reset.
BTNC  input  1  raw centre button (select/commit), asynchronous to clk.
BTNU  input  1  raw up button, asynchronous to clk.
BTND  input  1  raw down button, asynchronous to clk.
BTNL  input  1  raw left button, asynchronous to clk.
BTNR  input  1  raw right button, asynchronous to clk.
cursor_x  output  3  cursor column, 0 = left.
cursor_y  output  3  cursor row, 0 = top.
sel_active  output  1  a from-square is currently latched.
sel_x  output  3  latched from-square column.
sel_y  output  3  latched from-square row.
move_valid  output  1  move request pending.
move_from  output  6  source square index = sel_y*8 + sel_x.
move_to  output  6  destination square index = y*8 + x.
move_ready  input  1  the chess logic accepts the request.

Behaviour:
- Reset, asynchronous: all outputs 0; cursor at (0,0); FSM in IDLE; synchronisers, debounced levels and counters at 0.
- Per button, synchroniser: a 2-flop chain.
- Per button, debounce: if the synced input equals the debounced level, clear the counter. Otherwise increment it. When the counter reaches DEBOUNCE_CYCLES-1 while the input still differs, toggle the debounced level and clear the counter. A glitch shorter than DEBOUNCE_CYCLES resets the count and produces no change.
- Pulse: one-cycle pulse on each 0->1 transition of a debounced level. Releases produce nothing. There is no auto-repeat.
- Latency: from a raw press edge to its pulse = 2 sync cycles + DEBOUNCE_CYCLES cycles. The cursor or FSM updates on the following edge.
- Cursor, modulo 8 with wrap-around:
  - U pulse: y-1, so 0 wraps to 7.
  - D pulse: y+1, so 7 wraps to 0.
  - L pulse: x-1. R pulse: x+1.
  - U and D pulses in the same cycle: y unchanged. L and R in the same cycle: x unchanged.
  - Horizontal and vertical moves in the same cycle both apply.
  - The cursor moves in every FSM state.
- FSM states: IDLE, SELECTED, REQUEST.
  - IDLE: on a C pulse, latch sel_x/sel_y from the current (pre-move) cursor, set sel_active=1, go to SELECTED.
  - SELECTED, C pulse with cursor == sel (pre-move value): cancel. Set sel_active=0, go to IDLE.
  - SELECTED, C pulse with cursor != sel: register move_from = sel index and move_to = cursor index (pre-move). Set move_valid=1, go to REQUEST.
  - REQUEST: move_valid, move_from and move_to are held stable until a cycle where move_valid && move_ready. On that edge: move_valid=0, sel_active=0, go to IDLE. C pulses in REQUEST are ignored and dropped, not queued.
- A C pulse coinciding with a direction pulse always uses the cursor value from before that cycle's move.
- move_ready is ignored outside REQUEST.
- A reset asserted mid-operation or mid-request aborts it immediately. No request survives reset.

Test Plan:
- DEBOUNCE_CYCLES=4, BTNR held 10 cycles -> exactly one pulse, cursor_x 0->1 on cycle 2+4+1 after the press; releasing causes no change.
- BTNR toggled with 3-cycle bounces, then held stable -> no pulses during the bounce; one x increment after 4 stable cycles.
- From (0,0), one U press -> cursor_y=7. From x=7, one R press -> cursor_x=0. U and D pulses forced in the same cycle -> y unchanged.
- C at (4,6), move to (4,4), C, move_ready=0 for 5 cycles -> move_valid=1 with move_from=52 and move_to=36, held stable all 5 cycles. move_ready=1 -> move_valid=0, sel_active=0 the next cycle.
- C at (2,3), then C again without moving -> sel_active goes 1 then 0, move_valid never asserts.
- Assert reset while in REQUEST -> move_valid=0, sel_active=0 and cursor (0,0) immediately, with no clock edge needed.

Source files
------------

// File: rtl/button_cursor_ctrl.sv
// button_cursor_ctrl
//   Front-end input stage for the chess logic core. The five board buttons
//   are synchronised, debounced and turned into one-cycle press pulses. The
//   direction pulses move an 8x8 cursor with wrap-around. Two centre presses
//   (from-square, then a different to-square) become one move request,
//   offered to the chess logic over a valid/ready handshake.
//
// Ports
//   clk          25 MHz system clock
//   reset        asynchronous, active-high reset
//   BTNC         raw centre button (select / commit), asynchronous to clk
//   BTNU/D/L/R   raw direction buttons, asynchronous to clk
//   cursor_x/y   cursor column / row (0 = left / top)
//   sel_active   a from-square is latched
//   sel_x/sel_y  latched from-square
//   move_valid   move request pending
//   move_from    source square index      (sel_y*8 + sel_x)
//   move_to      destination square index (cursor_y*8 + cursor_x)
//   move_ready   chess logic accepts the pending request
module button_cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       BTNC,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNL,
    input  logic       BTNR,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       sel_active,
    output logic [2:0] sel_x,
    output logic [2:0] sel_y,
    output logic       move_valid,
    output logic [5:0] move_from,
    output logic [5:0] move_to,
    input  logic       move_ready
);

    localparam int NBTN = 5;
    // Button order inside the vectors below: 0=C, 1=U, 2=D, 3=L, 4=R.
    localparam int IC = 0;
    localparam int IU = 1;
    localparam int ID = 2;
    localparam int IL = 3;
    localparam int IR = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] pulse;

    assign raw = {BTNR, BTNL, BTND, BTNU, BTNC};

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             level_prev_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg      <= 1'b0;
                    sync2_reg      <= 1'b0;
                    level_reg      <= 1'b0;
                    level_prev_reg <= 1'b0;
                    cnt_reg        <= '0;
                end else begin
                    sync1_reg      <= raw[gi];
                    sync2_reg      <= sync1_reg;
                    level_prev_reg <= level_reg;
                    // Any cycle where the input agrees with the debounced level
                    // restarts the count, so a short glitch leaves no trace.
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        level_reg <= ~level_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            // Rising edge of the debounced level only; releases are silent.
            assign pulse[gi] = level_reg & ~level_prev_reg;
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECTED,
        ST_REQUEST
    } state_t;

    state_t     state_reg;
    logic [2:0] cursor_x_reg;
    logic [2:0] cursor_y_reg;
    logic [2:0] cursor_x_next;
    logic [2:0] cursor_y_next;
    logic       sel_active_reg;
    logic [2:0] sel_x_reg;
    logic [2:0] sel_y_reg;
    logic       move_valid_reg;
    logic [5:0] move_from_reg;
    logic [5:0] move_to_reg;

    // Opposing pulses in the same cycle cancel; 3-bit arithmetic wraps mod 8.
    always_comb begin
        cursor_x_next = cursor_x_reg;
        cursor_y_next = cursor_y_reg;
        if (pulse[IR] && !pulse[IL]) begin
            cursor_x_next = cursor_x_reg + 3'd1;
        end else if (pulse[IL] && !pulse[IR]) begin
            cursor_x_next = cursor_x_reg - 3'd1;
        end
        if (pulse[ID] && !pulse[IU]) begin
            cursor_y_next = cursor_y_reg + 3'd1;
        end else if (pulse[IU] && !pulse[ID]) begin
            cursor_y_next = cursor_y_reg - 3'd1;
        end
    end

    // Select / commit machine. It always compares and latches the registered
    // (pre-move) cursor, so a C press coinciding with a direction press acts on
    // the square the cursor was on before that cycle's move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cursor_x_reg   <= 3'd0;
            cursor_y_reg   <= 3'd0;
            sel_active_reg <= 1'b0;
            sel_x_reg      <= 3'd0;
            sel_y_reg      <= 3'd0;
            move_valid_reg <= 1'b0;
            move_from_reg  <= 6'd0;
            move_to_reg    <= 6'd0;
        end else begin
            cursor_x_reg <= cursor_x_next;
            cursor_y_reg <= cursor_y_next;
            case (state_reg)
                ST_IDLE: begin
                    if (pulse[IC]) begin
                        sel_x_reg      <= cursor_x_reg;
                        sel_y_reg      <= cursor_y_reg;
                        sel_active_reg <= 1'b1;
                        state_reg      <= ST_SELECTED;
                    end
                end
                ST_SELECTED: begin
                    if (pulse[IC]) begin
                        if (cursor_x_reg == sel_x_reg && cursor_y_reg == sel_y_reg) begin
                            sel_active_reg <= 1'b0;
                            state_reg      <= ST_IDLE;
                        end else begin
                            move_from_reg  <= {sel_y_reg, sel_x_reg};
                            move_to_reg    <= {cursor_y_reg, cursor_x_reg};
                            move_valid_reg <= 1'b1;
                            state_reg      <= ST_REQUEST;
                        end
                    end
                end
                ST_REQUEST: begin
                    // C presses here are dropped; the request payload stays put.
                    if (move_valid_reg && move_ready) begin
                        move_valid_reg <= 1'b0;
                        sel_active_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cursor_x   = cursor_x_reg;
    assign cursor_y   = cursor_y_reg;
    assign sel_active = sel_active_reg;
    assign sel_x      = sel_x_reg;
    assign sel_y      = sel_y_reg;
    assign move_valid = move_valid_reg;
    assign move_from  = move_from_reg;
    assign move_to    = move_to_reg;

endmodule

// File: tb/tb_button_cursor_ctrl.sv
// Directed bench for button_cursor_ctrl with a short debounce window.
// Expected values are queued when stimulus is driven and popped when the
// design's outputs are sampled (on the falling clock edge).
module tb_button_cursor_ctrl;

    localparam int DB = 4;
    localparam logic [4:0] B_C = 5'b00001;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b10000;

    logic       clk;
    logic       reset;
    logic [4:0] btn;
    logic       move_ready;
    logic [2:0] cursor_x;
    logic [2:0] cursor_y;
    logic       sel_active;
    logic [2:0] sel_x;
    logic [2:0] sel_y;
    logic       move_valid;
    logic [5:0] move_from;
    logic [5:0] move_to;

    int checks = 0;
    int errors = 0;

    string       tagq[$];
    logic [31:0] valq[$];

    logic [2:0] model_x = 3'd0;
    logic [2:0] model_y = 3'd0;

    button_cursor_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .BTNC(btn[0]),
        .BTNU(btn[1]),
        .BTND(btn[2]),
        .BTNL(btn[3]),
        .BTNR(btn[4]),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .sel_active(sel_active),
        .sel_x(sel_x),
        .sel_y(sel_y),
        .move_valid(move_valid),
        .move_from(move_from),
        .move_to(move_to),
        .move_ready(move_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish (checks %0d errors %0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic sb_push(input string tag, input logic [31:0] v);
        tagq.push_back(tag);
        valq.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        checks++;
        if (tagq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %0d expected none", obs);
            return;
        end
        tag = tagq.pop_front();
        exp = valq.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue the cursor the press of 'mask' should produce.
    task automatic drive(input logic [4:0] mask);
        if (mask[4] && !mask[3]) model_x = model_x + 3'd1;
        if (mask[3] && !mask[4]) model_x = model_x - 3'd1;
        if (mask[2] && !mask[1]) model_y = model_y + 3'd1;
        if (mask[1] && !mask[2]) model_y = model_y - 3'd1;
        sb_push("cursor_x", 32'(model_x));
        sb_push("cursor_y", 32'(model_y));
    endtask

    // Clean press: held 8 cycles, then released and given time to settle.
    task automatic press(input logic [4:0] mask);
        @(negedge clk);
        btn = mask;
        repeat (8) @(negedge clk);
        btn = 5'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_xy();
        sb_check(32'(cursor_x));
        sb_check(32'(cursor_y));
    endtask

    task automatic step(input logic [4:0] mask);
        drive(mask);
        press(mask);
        chk_xy();
    endtask

    initial begin
        reset      = 1'b1;
        btn        = 5'b0;
        move_ready = 1'b0;

        // Reset state
        @(negedge clk);
        sb_push("rst_x", 0); sb_push("rst_y", 0); sb_push("rst_sel", 0);
        sb_push("rst_valid", 0); sb_push("rst_from", 0); sb_push("rst_to", 0);
        sb_check(32'(cursor_x)); sb_check(32'(cursor_y)); sb_check(32'(sel_active));
        sb_check(32'(move_valid)); sb_check(32'(move_from)); sb_check(32'(move_to));
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // R held 10 cycles: x changes exactly on edge 2+4+1
        btn = B_R;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6 || k == 7 || k == 10) begin
                sb_push($sformatf("r_hold_k%0d", k), (k >= 7) ? 1 : 0);
                sb_check(32'(cursor_x));
            end
        end
        btn = 5'b0;
        repeat (12) @(negedge clk);
        sb_push("r_release", 1);
        sb_check(32'(cursor_x));
        model_x = 3'd1;

        // Bounces of 3 cycles produce nothing; a stable hold counts once
        for (int b = 0; b < 2; b++) begin
            btn = B_R;
            repeat (3) @(negedge clk);
            btn = 5'b0;
            repeat (3) @(negedge clk);
        end
        sb_push("bounce_x", 1);
        sb_check(32'(cursor_x));
        btn = B_R;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6 || k == 7) begin
                sb_push($sformatf("bounce_hold_k%0d", k), (k >= 7) ? 2 : 1);
                sb_check(32'(cursor_x));
            end
        end
        btn = 5'b0;
        repeat (12) @(negedge clk);
        model_x = 3'd2;

        // Wrap-around and simultaneous presses
        step(B_U);                              // y 0 -> 7
        for (int i = 0; i < 6; i++) step(B_R);  // x 2 -> 7 -> 0
        step(B_U | B_D);                        // y unchanged
        step(B_L | B_R);                        // x unchanged
        step(B_R | B_D);                        // diagonal (1,0)

        // Full move: (4,6) -> (4,4)
        for (int i = 0; i < 3; i++) step(B_R);
        step(B_U);
        step(B_U);                              // (4,6)
        drive(B_C);
        sb_push("sel_active", 1); sb_push("sel_x", 4); sb_push("sel_y", 6);
        press(B_C);
        chk_xy();
        sb_check(32'(sel_active)); sb_check(32'(sel_x)); sb_check(32'(sel_y));
        step(B_U);
        step(B_U);                              // (4,4)
        drive(B_C);
        sb_push("req_valid", 1); sb_push("req_from", 52); sb_push("req_to", 36);
        press(B_C);
        chk_xy();
        sb_check(32'(move_valid)); sb_check(32'(move_from)); sb_check(32'(move_to));
        for (int i = 0; i < 5; i++) begin
            sb_push("hold_valid", 1); sb_push("hold_from", 52); sb_push("hold_to", 36);
            @(negedge clk);
            sb_check(32'(move_valid)); sb_check(32'(move_from)); sb_check(32'(move_to));
        end
        // C during REQUEST is dropped
        drive(B_C);
        sb_push("drop_valid", 1); sb_push("drop_to", 36);
        press(B_C);
        chk_xy();
        sb_check(32'(move_valid)); sb_check(32'(move_to));
        move_ready = 1'b1;
        sb_push("ack_valid", 0); sb_push("ack_sel", 0);
        @(negedge clk);
        move_ready = 1'b0;
        sb_check(32'(move_valid)); sb_check(32'(sel_active));
        repeat (10) @(negedge clk);
        sb_push("no_queued_c", 0);
        sb_check(32'(sel_active));

        // Cancel: C twice on (2,3)
        step(B_L);
        step(B_L);
        step(B_U);                              // (2,3)
        drive(B_C);
        sb_push("cancel_sel1", 1); sb_push("cancel_sx", 2); sb_push("cancel_sy", 3);
        press(B_C);
        chk_xy();
        sb_check(32'(sel_active)); sb_check(32'(sel_x)); sb_check(32'(sel_y));
        drive(B_C);
        sb_push("cancel_sel0", 0); sb_push("cancel_valid", 0);
        press(B_C);
        chk_xy();
        sb_check(32'(sel_active)); sb_check(32'(move_valid));

        // Reset while a request is pending
        drive(B_C);
        press(B_C);
        chk_xy();
        step(B_R);                              // (3,3)
        drive(B_C);
        sb_push("pre_rst_valid", 1); sb_push("pre_rst_from", 26); sb_push("pre_rst_to", 27);
        press(B_C);
        chk_xy();
        sb_check(32'(move_valid)); sb_check(32'(move_from)); sb_check(32'(move_to));
        @(negedge clk);
        #2;
        reset = 1'b1;
        sb_push("arst_valid", 0); sb_push("arst_sel", 0);
        sb_push("arst_x", 0); sb_push("arst_y", 0); sb_push("arst_from", 0);
        #1;
        sb_check(32'(move_valid)); sb_check(32'(sel_active));
        sb_check(32'(cursor_x)); sb_check(32'(cursor_y)); sb_check(32'(move_from));
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        sb_push("post_rst_valid", 0);
        sb_check(32'(move_valid));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
